uart_cmd_rx: RTL
================

// Module: uart_cmd_rx
// PURPOSE
//  UART receiver on fpga_rxd, 8N1, LSB first. Decodes single-byte ASCII commands into held button pulses.
//  Outputs are OR-able with physical bt_w/a/s/d/st, so a host PC can drive mytank_app remotely.
//  Pairs with the board's fpga_txd transmit path; exports raw bytes and framing errors for debug LEDs.
// PARAMETERS
//  CLK_FREQ     100_000_000  system clock frequency in Hz
//  BAUD         9600         line rate; DIV = CLK_FREQ/BAUD (integer division), 10416 at defaults
//  HOLD_CYCLES  25_000_000   cycles a decoded button stays high (250 ms, covers at least one clk_4Hz sample)
// PORTS
//  clk        in   1  system clock (clk_100M domain)
//  rst_n      in   1  asynchronous active-low reset
//  fpga_rxd   in   1  serial input, idle high, asynchronous to clk
//  bt_w       out  1  remote "up"; held HOLD_CYCLES after 'w'/'W'
//  bt_a       out  1  remote "left"; held after 'a'/'A'
//  bt_s       out  1  remote "down"; held after 's'/'S'
//  bt_d       out  1  remote "right"; held after 'd'/'D'
//  bt_st      out  1  remote shoot; held after ' ' (0x20)
//  rx_data    out  8  last correctly framed byte
//  rx_valid   out  1  one-cycle strobe: rx_data updated
//  frame_err  out  1  one-cycle strobe: stop bit sampled low
// BEHAVIOUR
//  Reset: all outputs 0, rx_data 8'h00, FSM IDLE, counters 0. The synchronizer flops reset to 1 (idle line).
//  Input: 2-FF synchronizer; rxd_s is the second flop. Falling-edge detect uses a third flop.
//  FSM states: IDLE, START, DATA, STOP, BREAK.
//   IDLE:  on a falling edge of rxd_s, clear baud_cnt and go to START.
//   START: after DIV/2 cycles, sample rxd_s.
//          1 -> glitch, return to IDLE (no strobe).
//          0 -> clear baud_cnt and bit_idx, go to DATA.
//   DATA:  sample every DIV cycles, shifting into bit bit_idx, LSB first. After bit 7, go to STOP.
//   STOP:  sample after DIV cycles.
//          1 -> next cycle: rx_data <= shift reg, rx_valid=1 for 1 cycle, state IDLE.
//          0 -> frame_err=1 for 1 cycle, rx_data unchanged, state BREAK.
//   BREAK: wait until rxd_s==1, then IDLE. A held-low line never produces bytes.
//  baud_cnt width: $clog2(DIV)+1. It compares to DIV-1 (full bit) or DIV/2-1 (half bit) and wraps to 0.
//  Decode happens on the rx_valid cycle; the bt_* change is visible the following cycle. Case-insensitive.
//   Direction bytes: set the target button and load its hold counter with HOLD_CYCLES.
//    They also clear the other three direction buttons and counters, so at most one direction is high.
//   0x20: loads the shoot counter only. Independent of direction.
//   Any other byte: no effect on bt_*.
//   Repeat of the same command while held: counter reloads, output stays high with no gap.
//  Each hold counter decrements every cycle while nonzero. Its bt_* is high iff the counter is nonzero.
//  Latency: stop-bit mid-sample to rx_valid is 1 cycle. rx_valid to bt_* is 1 cycle.
//   Start edge to rx_valid is about 9.5*DIV + 4 cycles, including synchronizer delay.
//  Back-to-back frames: the start bit immediately after a stop bit is detected. The FSM returns to IDLE mid-stop-bit.
//  Reset mid-frame: immediate return to IDLE with outputs 0. The partial byte is discarded.
// TESTING (bench: CLK_FREQ=1_600_000, BAUD=100_000 -> DIV=16; HOLD_CYCLES=100)
//  1. Send 0x77 ('w') -> rx_valid pulses once with rx_data=8'h77.
//     bt_w high exactly 100 cycles starting 1 cycle later. Other bt_* stay 0.
//  2. Send 'D', then 'a' while bt_d is high -> bt_d drops the cycle bt_a rises.
//     Then send ' ' -> bt_st high 100 cycles while bt_a stays high.
//  3. Send 0x00 with stop bit forced low, line held low 40 cycles -> frame_err pulses once.
//     No rx_valid, rx_data keeps its previous value. The next good byte 0x41 is received normally.
//  4. Drive a 5-cycle low glitch on fpga_rxd -> no rx_valid, no frame_err, FSM back in IDLE.
//  5. Send 0x55, 0xAA, 0x73 back-to-back with no idle gap -> three rx_valid strobes, in order.
//     bt_s asserts after the third byte.
//  6. Deassert rst_n at bit 4 of a frame -> all outputs 0 immediately.
//     After release, a full 0x64 frame yields rx_valid and bt_d.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that turns single-byte ASCII commands into held button pulses
// (w/a/s/d directions, space for shoot), plus raw byte and framing-error strobes.
module uart_cmd_rx #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fpga_rxd,
  output logic       bt_w,
  output logic       bt_a,
  output logic       bt_s,
  output logic       bt_d,
  output logic       bt_st,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int DIV    = CLK_FREQ / BAUD;
  localparam int CNT_W  = $clog2(DIV) + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t state_r, state_nxt_s;

  logic             rxd_meta_r, rxd_sync_r, rxd_prev_r;
  logic             fall_s, half_hit_s, full_hit_s;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r, frame_err_r;
  logic             baud_clr_s, bit_clr_s, shift_en_s, byte_ok_s, byte_bad_s;

  // Direction slots: 0=w, 1=a, 2=s, 3=d.
  logic [3:0]             dir_hit_s;
  logic                   shoot_hit_s;
  logic [3:0][HOLD_W-1:0] dir_cnt_r, dir_cnt_nxt_s;
  logic [3:0]             bt_dir_r, bt_dir_nxt_s;
  logic [HOLD_W-1:0]      shoot_cnt_r, shoot_cnt_nxt_s;
  logic                   bt_st_r, bt_st_nxt_s;

  assign fall_s     = rxd_prev_r & ~rxd_sync_r;
  assign half_hit_s = (baud_cnt_r == HALF_LAST);
  assign full_hit_s = (baud_cnt_r == FULL_LAST);

  // Line synchronizer and falling-edge history, idling high like the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= fpga_rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Receiver next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) state_nxt_s = ST_START;
        else        state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (half_hit_s) state_nxt_s = rxd_sync_r ? ST_IDLE : ST_DATA;
        else            state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (full_hit_s && (bit_idx_r == 3'd7)) state_nxt_s = ST_STOP;
        else                                   state_nxt_s = ST_DATA;
      end
      ST_STOP: begin
        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
        if (full_hit_s) state_nxt_s = rxd_sync_r ? ST_IDLE : ST_BREAK;
        else            state_nxt_s = ST_STOP;
      end
      ST_BREAK: begin
        if (rxd_sync_r) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_BREAK;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Receiver datapath controls decoded from the current state.
  always_comb begin
    baud_clr_s = 1'b0;
    bit_clr_s  = 1'b0;
    shift_en_s = 1'b0;
    byte_ok_s  = 1'b0;
    byte_bad_s = 1'b0;
    case (state_r)
      ST_IDLE:  baud_clr_s = 1'b1;
      ST_START: begin
        if (half_hit_s) begin
          baud_clr_s = 1'b1;
          bit_clr_s  = 1'b1;
        end else begin
          baud_clr_s = 1'b0;
        end
      end
      ST_DATA: begin
        if (full_hit_s) begin
          baud_clr_s = 1'b1;
          shift_en_s = 1'b1;
        end else begin
          baud_clr_s = 1'b0;
        end
      end
      ST_STOP: begin
        if (full_hit_s) begin
          baud_clr_s = 1'b1;
          byte_ok_s  = rxd_sync_r;
          byte_bad_s = ~rxd_sync_r;
        end else begin
          baud_clr_s = 1'b0;
        end
      end
      ST_BREAK: baud_clr_s = 1'b1;
      default:  baud_clr_s = 1'b1;
    endcase
  end

  // Bit timing, shift register and byte/error strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_r  <= CNT_ZERO;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      baud_cnt_r  <= baud_clr_s ? CNT_ZERO : (baud_cnt_r + CNT_ONE);
      if (bit_clr_s)       bit_idx_r <= 3'd0;
      else if (shift_en_s) bit_idx_r <= bit_idx_r + 3'd1;
      if (shift_en_s)      shift_r[bit_idx_r] <= rxd_sync_r;
      if (byte_ok_s)       rx_data_r <= shift_r;
      rx_valid_r  <= byte_ok_s;
      frame_err_r <= byte_bad_s;
    end
  end

  // Case-insensitive command decode on the byte strobe.
  always_comb begin
    dir_hit_s   = 4'b0000;
    shoot_hit_s = 1'b0;
    if (rx_valid_r) begin
      case (rx_data_r)
        8'h77, 8'h57: dir_hit_s   = 4'b0001;
        8'h61, 8'h41: dir_hit_s   = 4'b0010;
        8'h73, 8'h53: dir_hit_s   = 4'b0100;
        8'h64, 8'h44: dir_hit_s   = 4'b1000;
        8'h20:        shoot_hit_s = 1'b1;
        default:      dir_hit_s   = 4'b0000;
      endcase
    end else begin
      dir_hit_s = 4'b0000;
    end
  end

  // Hold counters: a direction command reloads its own slot and clears the others.
  always_comb begin
    dir_cnt_nxt_s = {4*HOLD_W{1'b0}};
    bt_dir_nxt_s  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (dir_hit_s[i])                 dir_cnt_nxt_s[i] = HOLD_LOAD;
      else if (|dir_hit_s)              dir_cnt_nxt_s[i] = HOLD_ZERO;
      else if (dir_cnt_r[i] != HOLD_ZERO) dir_cnt_nxt_s[i] = dir_cnt_r[i] - HOLD_ONE;
      else                              dir_cnt_nxt_s[i] = dir_cnt_r[i];
      bt_dir_nxt_s[i] = (dir_cnt_nxt_s[i] != HOLD_ZERO);
    end
    if (shoot_hit_s)                  shoot_cnt_nxt_s = HOLD_LOAD;
    else if (shoot_cnt_r != HOLD_ZERO) shoot_cnt_nxt_s = shoot_cnt_r - HOLD_ONE;
    else                              shoot_cnt_nxt_s = shoot_cnt_r;
    bt_st_nxt_s = (shoot_cnt_nxt_s != HOLD_ZERO);
  end

  // Hold counter and button output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_cnt_r   <= {4*HOLD_W{1'b0}};
      bt_dir_r    <= 4'b0000;
      shoot_cnt_r <= HOLD_ZERO;
      bt_st_r     <= 1'b0;
    end else begin
      dir_cnt_r   <= dir_cnt_nxt_s;
      bt_dir_r    <= bt_dir_nxt_s;
      shoot_cnt_r <= shoot_cnt_nxt_s;
      bt_st_r     <= bt_st_nxt_s;
    end
  end

  assign bt_w      = bt_dir_r[0];
  assign bt_a      = bt_dir_r[1];
  assign bt_s      = bt_dir_r[2];
  assign bt_d      = bt_dir_r[3];
  assign bt_st     = bt_st_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;

endmodule
